// File: rtl/add_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_sched_pkg
// Description : Shared types and constants for the multi-word add scheduler:
//               chunk width, FSM state encoding and the chunk-index width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package add_sched_pkg;

    // Width of one chunk handled by the shared adder per cycle.
    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk index width; at least one bit so WORDS=1 still has a legal vector.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multiword_add_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant. The requester named by i_ptr wins
//               when it is valid; otherwise the other valid requester wins.
// Ports       : i_valid [1:0]  request vector
//               i_ptr          index holding priority this round
//               o_grant [1:0]  one-hot grant (zero when nothing is valid)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    logic w_other;

    assign w_other = ~i_ptr;

    always_comb begin
        o_grant = 2'b00;
        if (i_valid[i_ptr]) begin
            o_grant[i_ptr] = 1'b1;
        end else if (i_valid[w_other]) begin
            o_grant[w_other] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multiword_add_sched.sv
`default_nettype none
// ============================================================================
// Module      : multiword_add_sched
// Description : Shares one external combinational 16-bit adder between two
//               requesters. Each WORDS*16-bit addition is serialised over the
//               adder one chunk per cycle, LSB chunk first, with the carry
//               registered between chunks.
// Ports       : clk, rst_n              clock, async active-low reset
//               req_valid/ready [1:0]   per-requester handshake (ready one-hot)
//               req_a/req_b [2*W]       operands, requester i at [i*W +: W]
//               req_cin [1:0]           per-requester carry-in
//               rsp_valid/ready         result handshake
//               rsp_id, rsp_sum, rsp_cout  result owner, W-bit sum, carry out
//               add_a/add_b/add_cin     chunk drive to the shared adder
//               add_sum/add_cout        shared adder result
// Revision    : 1.0 - initial release
// ============================================================================
module multiword_add_sched
    import add_sched_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [2*CHUNK_W*WORDS-1:0] req_a,
    input  logic [2*CHUNK_W*WORDS-1:0] req_b,
    input  logic [1:0]                 req_cin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [CHUNK_W*WORDS-1:0]   rsp_sum,
    output logic                       rsp_cout,
    output logic [CHUNK_W-1:0]         add_a,
    output logic [CHUNK_W-1:0]         add_b,
    output logic                       add_cin,
    input  logic [CHUNK_W-1:0]         add_sum,
    input  logic                       add_cout
);

    localparam int W     = CHUNK_W * WORDS;
    localparam int IDX_W = idx_width(WORDS);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WORDS - 1);

    state_t             r_state;
    logic               r_rr_ptr;
    logic               r_id;
    logic               r_carry;
    logic               r_rsp_valid;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic [CHUNK_W-1:0] r_sum [WORDS];

    logic [1:0]         w_grant;
    logic [W-1:0]       w_sel_a;
    logic [W-1:0]       w_sel_b;
    logic               w_sel_cin;
    logic [CHUNK_W-1:0] w_a_chunk [WORDS];
    logic [CHUNK_W-1:0] w_b_chunk [WORDS];
    logic [W-1:0]       w_sum_packed;

    rr_arb2 u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    // Operand mux driven by the one-hot grant.
    assign w_sel_a   = w_grant[1] ? req_a[2*W-1:W] : req_a[W-1:0];
    assign w_sel_b   = w_grant[1] ? req_b[2*W-1:W] : req_b[W-1:0];
    assign w_sel_cin = w_grant[1] ? req_cin[1]     : req_cin[0];

    // Chunk views of the latched operands and the packed sum.
    for (genvar k = 0; k < WORDS; k++) begin : g_chunk
        assign w_a_chunk[k] = r_op_a[k*CHUNK_W +: CHUNK_W];
        assign w_b_chunk[k] = r_op_b[k*CHUNK_W +: CHUNK_W];
        assign w_sum_packed[k*CHUNK_W +: CHUNK_W] = r_sum[k];
    end

    // Grant is only offered in IDLE; gated by rst_n so every output reads
    // zero as soon as reset is asserted.
    assign req_ready = (r_state == IDLE && rst_n) ? w_grant : 2'b00;

    assign add_a   = (r_state == RUN) ? w_a_chunk[r_idx] : '0;
    assign add_b   = (r_state == RUN) ? w_b_chunk[r_idx] : '0;
    assign add_cin = (r_state == RUN) ? r_carry : 1'b0;

    // Result fields are qualified by the registered valid so they read zero
    // while no response is being presented.
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_valid & r_id;
    assign rsp_cout  = r_rsp_valid & r_carry;
    assign rsp_sum   = r_rsp_valid ? w_sum_packed : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= 1'b0;
            r_id        <= 1'b0;
            r_carry     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_idx       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            for (int k = 0; k < WORDS; k++) begin
                r_sum[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_op_a  <= w_sel_a;
                        r_op_b  <= w_sel_b;
                        r_carry <= w_sel_cin;
                        r_id    <= w_grant[1];
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx] <= add_sum;
                    r_carry      <= add_cout;
                    if (r_idx == c_last_idx) begin
                        r_idx       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        // Hand priority to the requester that was not served.
                        r_rr_ptr    <= ~r_id;
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiword_add_sched
// Description : Self-checking bench for multiword_add_sched (WORDS=4) with a
//               16-bit ripple adder attached. Table-driven directed vectors,
//               hand-written arbitration / stall / reset sequences and a
//               randomized back-to-back run against a plain-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multiword_add_sched;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    typedef logic [W:0] val_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_cin;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic [15:0]    add_a;
    logic [15:0]    add_b;
    logic           add_cin;
    logic [15:0]    add_sum;
    logic           add_cout;

    int n_cmp;
    int n_bad;
    int cyc;

    multiword_add_sched #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // Shared combinational 16-bit adder living in the parent.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference: the whole W-bit addition in one step.
    function automatic val_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin);
        return {1'b0, a} + {1'b0, b} + val_t'(cin);
    endfunction

    task automatic chk(input string nm, input val_t act, input val_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int id);
        int n;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
    endtask

    // One full transaction from a single requester, with latency and first
    // chunk drive checked along the way.
    task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input string nm);
        int lat;
        @(negedge clk);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_cin[id]      = cin;
        req_valid[id]    = 1'b1;
        #1;
        wait_ready(id);
        chk({nm, " ready"}, val_t'(req_ready), val_t'(2'b01 << id));
        @(negedge clk); #1;
        req_valid[id] = 1'b0;
        chk({nm, " chunk0"}, val_t'({add_cin, add_a, add_b}),
            val_t'({cin, a[15:0], b[15:0]}));
        wait_rsp(lat);
        chk({nm, " latency"}, val_t'(lat), val_t'(WORDS + 1));
        chk({nm, " id"}, val_t'(rsp_id), val_t'(id));
        chk({nm, " sum"}, {rsp_cout, rsp_sum}, {exp_cout, exp_sum});
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, " rsp drop"}, val_t'(rsp_valid), val_t'(0));
    endtask

    vec_t          vecs [6];
    logic [W-1:0]  a0, b0, a1, b1, ta, tb;
    logic          tc;
    logic [W-1:0]  held_sum;
    val_t          r;
    int            lat, t_prev, t_acc;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 2'b00;
        rsp_ready = 1'b0;

        vecs[0] = '{0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
        vecs[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vecs[2] = '{0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0};
        vecs[3] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        vecs[4] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[5] = '{1, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                    64'h0001_0000_0001_0000, 1'b0};

        // Reset state.
        #12;
        chk("reset outputs", val_t'({req_ready, rsp_valid, rsp_id, rsp_cout, add_cin}), val_t'(0));
        chk("reset add_a/b", val_t'({add_a, add_b}), val_t'(0));
        chk("reset rsp_sum", val_t'(rsp_sum), val_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle no ready", val_t'({req_ready, rsp_valid}), val_t'(0));

        // Both valid right after reset: 0, 1, 0 alternation.
        a0 = 64'h0123_4567_89AB_CDEF; b0 = 64'hFEDC_BA98_7654_3210;
        a1 = 64'hDEAD_BEEF_0000_FFFF; b1 = 64'h2152_4111_FFFF_0001;
        @(negedge clk);
        req_a = {a1, a0}; req_b = {b1, b0}; req_cin = 2'b10; req_valid = 2'b11;
        #1;
        for (int k = 0; k < 3; k++) begin
            int eid;
            eid = k % 2;
            wait_ready(eid);
            chk($sformatf("arb grant %0d", k), val_t'(req_ready), val_t'(2'b01 << eid));
            @(negedge clk); #1;
            wait_rsp(lat);
            chk($sformatf("arb id %0d", k), val_t'(rsp_id), val_t'(eid));
            r = (eid == 0) ? ref_add(a0, b0, 1'b0) : ref_add(a1, b1, 1'b1);
            chk($sformatf("arb sum %0d", k), {rsp_cout, rsp_sum}, r);
            rsp_ready = 1'b1;
            @(negedge clk); #1;
            rsp_ready = 1'b0;
        end
        req_valid = 2'b00;

        // Directed table.
        foreach (vecs[i]) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));
        end

        // Consumer stalls 10 cycles in DONE while the other requester waits.
        @(negedge clk);
        req_a[W-1:0] = 64'h0000_1111_2222_3333; req_b[W-1:0] = 64'h0000_4444_5555_6666;
        req_cin[0] = 1'b0; req_valid[0] = 1'b1;
        #1;
        wait_ready(0);
        @(negedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(lat);
        req_valid[1] = 1'b1;
        held_sum = 64'h0000_5555_7777_9999;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            chk($sformatf("stall %0d hold", k), {rsp_valid, rsp_cout, rsp_sum},
                {2'b10, held_sum});
            chk($sformatf("stall %0d no accept", k), val_t'(req_ready), val_t'(0));
        end
        req_valid[1] = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during RUN at chunk index 2.
        @(negedge clk);
        ta = 64'hAAAA_5A5A_3C3C_0F0F; tb = 64'h1111_2222_3333_4444;
        req_a[W-1:0] = ta; req_b[W-1:0] = tb; req_cin[0] = 1'b1; req_valid[0] = 1'b1;
        #1;
        wait_ready(0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("run idx2 add_a", val_t'(add_a), val_t'(ta[47:32]));
        rst_n = 1'b0;
        #1;
        chk("abort outputs", val_t'({req_ready, rsp_valid, rsp_id, rsp_cout, add_cin}), val_t'(0));
        chk("abort add_a/b", val_t'({add_a, add_b}), val_t'(0));
        chk("abort rsp_sum", val_t'(rsp_sum), val_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            chk($sformatf("post-abort idle %0d", k), val_t'({rsp_valid, req_ready}), val_t'(0));
        end
        r = ref_add(ta, tb, 1'b1);
        run_op(0, ta, tb, 1'b1, r[W-1:0], r[W], "post-abort op");

        // Randomized back-to-back from requester 0, consumer always ready.
        rsp_ready = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ta = {$urandom, $urandom};
            tb = {$urandom, $urandom};
            tc = 1'($urandom_range(0, 1));
            if (k == 3) begin
                ta = '1;
                tb = 64'h1;
            end
            req_a[W-1:0] = ta; req_b[W-1:0] = tb; req_cin[0] = tc; req_valid[0] = 1'b1;
            #1;
            wait_ready(0);
            t_acc = cyc;
            if (k > 0) chk($sformatf("b2b cadence %0d", k), val_t'(t_acc - t_prev), val_t'(WORDS + 2));
            t_prev = t_acc;
            r = ref_add(ta, tb, tc);
            @(negedge clk); #1;
            wait_rsp(lat);
            chk($sformatf("b2b result %0d", k), {rsp_cout, rsp_sum}, r);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
